// File: rtl/ip_tx_arbiter.sv
// rtl/ip_tx_arbiter.sv - round-robin share of one IP header inserter between two UDP payload sources
// Optional payload length checker: define IP_ARB_LENCHK_EN.
module ip_tx_arbiter #(
  parameter int MAX_PAYLOAD  = 1480,
  parameter int SETUP_CYCLES = 2,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [31:0] local_ip,
  input  logic        src0_req,
  input  logic [15:0] src0_len,
  input  logic [31:0] src0_dest,
  output logic        src0_grant,
  output logic        src0_ack,
  output logic        src0_err,
  input  logic [7:0]  src0_axis_tdata,
  input  logic        src0_axis_tlast,
  input  logic        src0_axis_tvalid,
  output logic        src0_axis_tready,
  input  logic        src1_req,
  input  logic [15:0] src1_len,
  input  logic [31:0] src1_dest,
  output logic        src1_grant,
  output logic        src1_ack,
  output logic        src1_err,
  input  logic [7:0]  src1_axis_tdata,
  input  logic        src1_axis_tlast,
  input  logic        src1_axis_tvalid,
  output logic        src1_axis_tready,
  output logic [15:0] ip_TotLen,
  output logic [31:0] ip_SrcAddr,
  output logic [31:0] ip_DestAddr,
  output logic        ip_enable,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PASS  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [16:0] MAX_LEN    = 17'(MAX_PAYLOAD);
  localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(IFG_CYCLES - 1);

  logic [2:0]  state;
  logic        last_grant;
  logic        sel;
  logic [7:0]  cnt;
  logic [15:0] beat_cnt;
  logic [15:0] beat_next;

  logic        pick;
  logic        take_req;
  logic [15:0] pick_len;
  logic [31:0] pick_dest;
  logic        len_bad;

  logic        in_pass;
  logic        in_drain;
  logic [7:0]  src_tdata;
  logic        src_tlast;
  logic        src_tvalid;
  logic        src_ready;
  logic        xfer;
  logic        at_len;
  logic        short_err;

  always_comb begin
    pick = 1'b0;
    if (src0_req && src1_req)
      pick = ~last_grant;
    else if (src1_req)
      pick = 1'b1;
  end

  // An ack still on the wire means the requester has not yet had a chance to drop req.
  assign take_req  = (src0_req || src1_req) && !src0_ack && !src1_ack;
  assign pick_len  = pick ? src1_len : src0_len;
  assign pick_dest = pick ? src1_dest : src0_dest;
  assign len_bad   = (pick_len == 16'd0) || ({1'b0, pick_len} > MAX_LEN);

  assign in_pass    = (state == ST_PASS);
  assign in_drain   = (state == ST_DRAIN);
  assign src_tdata  = sel ? src1_axis_tdata  : src0_axis_tdata;
  assign src_tlast  = sel ? src1_axis_tlast  : src0_axis_tlast;
  assign src_tvalid = sel ? src1_axis_tvalid : src0_axis_tvalid;
  assign xfer       = in_pass && src_tvalid && m_axis_tready;
  assign beat_next  = beat_cnt + 16'd1;

`ifdef IP_ARB_LENCHK_EN
  assign at_len    = ((beat_next + 16'd20) == ip_TotLen);
  assign short_err = !at_len;
`else
  assign at_len    = 1'b0;
  assign short_err = 1'b0;
`endif

  assign m_axis_tvalid = in_pass && src_tvalid;
  assign m_axis_tdata  = in_pass ? src_tdata : 8'd0;
  assign m_axis_tlast  = in_pass && (src_tlast || at_len);
  assign m_axis_tuser  = in_pass && src_tvalid && (beat_cnt == 16'd0);

  // DRAIN swallows the overrun of a too-long packet regardless of the sink.
  assign src_ready        = in_pass ? m_axis_tready : in_drain;
  assign src0_axis_tready = !sel && src_ready;
  assign src1_axis_tready = sel && src_ready;
  assign src0_grant       = !sel && (state == ST_SETUP || in_pass);
  assign src1_grant       = sel && (state == ST_SETUP || in_pass);
  assign ip_enable        = (state != ST_IDLE);
  assign busy             = (state != ST_IDLE);

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      sel         <= 1'b0;
      cnt         <= 8'd0;
      beat_cnt    <= 16'd0;
      ip_TotLen   <= 16'd0;
      ip_SrcAddr  <= 32'd0;
      ip_DestAddr <= 32'd0;
      src0_ack    <= 1'b0;
      src1_ack    <= 1'b0;
      src0_err    <= 1'b0;
      src1_err    <= 1'b0;
    end else begin
      ip_SrcAddr <= local_ip;
      src0_ack   <= 1'b0;
      src1_ack   <= 1'b0;
      src0_err   <= 1'b0;
      src1_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_req) begin
            last_grant <= pick;
            sel        <= pick;
            if (len_bad) begin
              src0_ack <= ~pick;
              src1_ack <= pick;
              src0_err <= ~pick;
              src1_err <= pick;
            end else begin
              ip_TotLen   <= pick_len + 16'd20;
              ip_DestAddr <= pick_dest;
              cnt         <= 8'd0;
              state       <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          beat_cnt <= 16'd0;
          if (cnt == SETUP_LAST) begin
            cnt   <= 8'd0;
            state <= ST_PASS;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_PASS: begin
          if (xfer) begin
            beat_cnt <= beat_next;
            if (src_tlast) begin
              src0_ack <= ~sel;
              src1_ack <= sel;
              src0_err <= ~sel && short_err;
              src1_err <= sel && short_err;
              cnt      <= 8'd0;
              state    <= ST_GAP;
            end else if (at_len) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (src_tvalid && src_tlast) begin
            src0_ack <= ~sel;
            src1_ack <= sel;
            src0_err <= ~sel;
            src1_err <= sel;
            cnt      <= 8'd0;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 8'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
